command_handler: RTL and testbench

// Upstream writer for the 64x16 character buffer: consumes received bytes (valid/ready), interprets

---
 rtl/command_handler.sv | 223 ++++++++++++++++++++++
 tb/tb_command_handler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/command_handler.sv
// -----------------------------------------------------------------------------
// command_handler
// Upstream writer for the 64x16 character buffer. Consumes received bytes
// (valid/ready) and interprets printable characters, CR/LF/BS and VT52 ESC
// sequences. Drives the buffer write port, the cursor position and the
// hardware-scroll offset read by the video/scan stage.
//
// Ports
//   pclk        in   1   clock, rising edge
//   clr         in   1   asynchronous active-high reset
//   data        in   8   received byte
//   valid       in   1   data valid
//   ready       out  1   byte accepted when valid && ready; low while clearing
//   buffer_din  out  8   character to write
//   buffer_addr out  10  {physical row, column}
//   buffer_wen  out  1   write strobe, one cycle per cell
//   cursor_x    out  6   cursor column
//   cursor_y    out  4   cursor logical row
//   first_row   out  4   physical row shown as logical row 0
// -----------------------------------------------------------------------------
module command_handler #(
    parameter int         COLS_LOG2 = 6,
    parameter int         ROWS_LOG2 = 4,
    parameter logic [7:0] BLANK     = 8'h20
) (
    input  logic                           pclk,
    input  logic                           clr,
    input  logic [7:0]                     data,
    input  logic                           valid,
    output logic                           ready,
    output logic [7:0]                     buffer_din,
    output logic [COLS_LOG2+ROWS_LOG2-1:0] buffer_addr,
    output logic                           buffer_wen,
    output logic [COLS_LOG2-1:0]           cursor_x,
    output logic [ROWS_LOG2-1:0]           cursor_y,
    output logic [ROWS_LOG2-1:0]           first_row
);

    localparam int AW = COLS_LOG2 + ROWS_LOG2;
    localparam logic [COLS_LOG2-1:0] X_MAX   = '1;
    localparam logic [ROWS_LOG2-1:0] Y_MAX   = '1;
    localparam logic [7:0]           COL_LIM = 8'((1 << COLS_LOG2) - 1);
    localparam logic [7:0]           ROW_LIM = 8'((1 << ROWS_LOG2) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_ESC_Y_ROW,
        S_ESC_Y_COL,
        S_CLEAR
    } state_t;

    state_t                 state, state_n;
    logic [COLS_LOG2-1:0]   x_n;
    logic [ROWS_LOG2-1:0]   y_n, fr_n, esc_row, esc_row_n;
    logic [AW-1:0]          clr_idx, clr_idx_n, clr_end, clr_end_n;
    logic [AW-1:0]          addr_n;
    logic [7:0]             din_n;
    logic                   wen_n;

    // Clear request raised by the command decode, serviced in one place below.
    logic                   clr_go;
    logic [AW-1:0]          clr_start, clr_stop;
    logic [7:0]             ch_off;
    logic                   accept;

    // Logical (row, col) index -> physical buffer address under scroll offset fr.
    function automatic logic [AW-1:0] phys(input logic [AW-1:0] l,
                                           input logic [ROWS_LOG2-1:0] fr);
        logic [ROWS_LOG2-1:0] row;
        row = l[AW-1:COLS_LOG2] + fr;
        return {row, l[COLS_LOG2-1:0]};
    endfunction

    assign ready  = (state != S_CLEAR);
    assign accept = valid && ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_n   = state;
        x_n       = cursor_x;
        y_n       = cursor_y;
        fr_n      = first_row;
        esc_row_n = esc_row;
        clr_idx_n = clr_idx;
        clr_end_n = clr_end;
        addr_n    = buffer_addr;
        din_n     = buffer_din;
        wen_n     = 1'b0;
        clr_go    = 1'b0;
        clr_start = '0;
        clr_stop  = '0;
        ch_off    = data - 8'd32;

        case (state)
            S_IDLE: if (accept) begin
                if (data >= 8'h20 && data <= 8'h7E) begin
                    wen_n  = 1'b1;
                    din_n  = data;
                    addr_n = phys({cursor_y, cursor_x}, first_row);
                    // No auto-wrap: the last column is simply overwritten.
                    if (cursor_x != X_MAX) x_n = cursor_x + 1'b1;
                end else begin
                    case (data)
                        8'h08: if (cursor_x != '0) x_n = cursor_x - 1'b1;
                        8'h0D: x_n = '0;
                        8'h0A: begin
                            if (cursor_y != Y_MAX) begin
                                y_n = cursor_y + 1'b1;
                            end else begin
                                // Scroll by rotating the offset, then blank the
                                // row that became the bottom line.
                                fr_n      = first_row + 1'b1;
                                clr_go    = 1'b1;
                                clr_start = {Y_MAX, {COLS_LOG2{1'b0}}};
                                clr_stop  = '1;
                            end
                        end
                        8'h1B:   state_n = S_ESC;
                        default: ;
                    endcase
                end
            end

            S_ESC: if (accept) begin
                state_n = S_IDLE;
                case (data)
                    8'h41: if (cursor_y != '0)    y_n = cursor_y - 1'b1;
                    8'h42: if (cursor_y != Y_MAX) y_n = cursor_y + 1'b1;
                    8'h43: if (cursor_x != X_MAX) x_n = cursor_x + 1'b1;
                    8'h44: if (cursor_x != '0)    x_n = cursor_x - 1'b1;
                    8'h48: begin
                        x_n = '0;
                        y_n = '0;
                    end
                    8'h4A: begin
                        clr_go    = 1'b1;
                        clr_start = {cursor_y, cursor_x};
                        clr_stop  = '1;
                    end
                    8'h4B: begin
                        clr_go    = 1'b1;
                        clr_start = {cursor_y, cursor_x};
                        clr_stop  = {cursor_y, X_MAX};
                    end
                    8'h59:   state_n = S_ESC_Y_ROW;
                    default: ;
                endcase
            end

            S_ESC_Y_ROW: if (accept) begin
                if (data < 8'd32)          esc_row_n = '0;
                else if (ch_off > ROW_LIM) esc_row_n = Y_MAX;
                else                       esc_row_n = ch_off[ROWS_LOG2-1:0];
                state_n = S_ESC_Y_COL;
            end

            S_ESC_Y_COL: if (accept) begin
                y_n = esc_row;
                if (data < 8'd32)          x_n = '0;
                else if (ch_off > COL_LIM) x_n = X_MAX;
                else                       x_n = ch_off[COLS_LOG2-1:0];
                state_n = S_IDLE;
            end

            S_CLEAR: begin
                // clr_idx is the index currently on the write port; stop after
                // the end index has been shown, so the index never wraps.
                if (clr_idx == clr_end) begin
                    state_n = S_IDLE;
                end else begin
                    clr_idx_n = clr_idx + 1'b1;
                    wen_n     = 1'b1;
                    din_n     = BLANK;
                    addr_n    = phys(clr_idx + 1'b1, first_row);
                end
            end

            default: state_n = S_IDLE;
        endcase

        // First clear write goes out with the acceptance, using the scroll
        // offset as updated by that same command.
        if (clr_go) begin
            state_n   = S_CLEAR;
            clr_idx_n = clr_start;
            clr_end_n = clr_stop;
            wen_n     = 1'b1;
            din_n     = BLANK;
            addr_n    = phys(clr_start, fr_n);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge pclk or posedge clr) begin
        if (clr) begin
            state       <= S_IDLE;
            cursor_x    <= '0;
            cursor_y    <= '0;
            first_row   <= '0;
            esc_row     <= '0;
            clr_idx     <= '0;
            clr_end     <= '0;
            buffer_addr <= '0;
            buffer_din  <= '0;
            buffer_wen  <= 1'b0;
        end else begin
            state       <= state_n;
            cursor_x    <= x_n;
            cursor_y    <= y_n;
            first_row   <= fr_n;
            esc_row     <= esc_row_n;
            clr_idx     <= clr_idx_n;
            clr_end     <= clr_end_n;
            buffer_addr <= addr_n;
            buffer_din  <= din_n;
            buffer_wen  <= wen_n;
        end
    end

endmodule

// File: tb/tb_command_handler.sv
// -----------------------------------------------------------------------------
// tb_command_handler
// Directed stimulus for command_handler. Expected buffer writes are queued as
// commands are issued; a monitor pops and compares on every write strobe.
// Cursor, scroll offset and ready are checked directly by the stimulus.
// -----------------------------------------------------------------------------
module tb_command_handler;

    logic       pclk;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [7:0] buffer_din;
    logic [9:0] buffer_addr;
    logic       buffer_wen;
    logic [5:0] cursor_x;
    logic [3:0] cursor_y;
    logic [3:0] first_row;

    command_handler dut (
        .pclk        (pclk),
        .clr         (clr),
        .data        (data),
        .valid       (valid),
        .ready       (ready),
        .buffer_din  (buffer_din),
        .buffer_addr (buffer_addr),
        .buffer_wen  (buffer_wen),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .first_row   (first_row)
    );

    typedef struct {
        logic [9:0] addr;
        logic [7:0] din;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [9:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.din  = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge pclk) begin
        if (!clr && buffer_wen) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h din 0x%0h, none expected",
                         buffer_addr, buffer_din);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 32'(buffer_addr), 32'(w.addr));
                check("write_din",  32'(buffer_din),  32'(w.din));
            end
        end
    end

    // Waits (bounded) for ready, then presents one byte for exactly one edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!ready && n < 3000) begin
            @(posedge pclk);
            #1;
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        data  = b;
        valid = 1'b1;
        @(posedge pclk);
        #1;
        valid = 1'b0;
    endtask

    // Called just after an accepting edge: counts cycles with ready low.
    task automatic count_busy(output int n);
        n = 0;
        while (!ready && n < 3000) begin
            @(posedge pclk);
            #1;
            n++;
        end
    endtask

    task automatic expect_cursor(input string name, input int y, input int x);
        check({name, "_y"}, 32'(cursor_y), 32'(y));
        check({name, "_x"}, 32'(cursor_x), 32'(x));
    endtask

    int busy;

    initial begin
        clr   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_wen", 32'(buffer_wen), 32'd0);
        clr = 1'b0;
        @(posedge pclk);
        #1;
        check("rst_ready",     32'(ready),       32'd1);
        check("rst_addr",      32'(buffer_addr), 32'd0);
        check("rst_din",       32'(buffer_din),  32'd0);
        check("rst_first_row", 32'(first_row),   32'd0);
        expect_cursor("rst", 0, 0);

        // "AB" at the origin.
        push(10'h000, 8'h41);
        push(10'h001, 8'h42);
        send(8'h41);
        check("ab_ready", 32'(ready), 32'd1);
        send(8'h42);
        check("ab_ready2", 32'(ready), 32'd1);
        expect_cursor("ab", 0, 2);

        // CR, then 66 'Z': last column is overwritten three times.
        send(8'h0D);
        expect_cursor("cr", 0, 0);
        for (int i = 0; i < 66; i++) push(10'(i > 63 ? 63 : i), 8'h5A);
        for (int i = 0; i < 66; i++) begin
            send(8'h5A);
            if (i >= 63) check("zz_x_sat", 32'(cursor_x), 32'd63);
        end

        // BS, ESC cursor moves, ignored bytes.
        send(8'h08);
        expect_cursor("bs", 0, 62);
        send(8'h1B); send(8'h44);
        expect_cursor("esc_d", 0, 61);
        send(8'h1B); send(8'h43);
        expect_cursor("esc_c", 0, 62);
        send(8'h1B); send(8'h48);
        expect_cursor("esc_h", 0, 0);
        send(8'h1B); send(8'h41);
        expect_cursor("esc_a_sat", 0, 0);
        send(8'h08);
        expect_cursor("bs_sat", 0, 0);
        send(8'h1B); send(8'h42);
        expect_cursor("esc_b", 1, 0);
        send(8'h7F);
        send(8'h1B); send(8'h51);
        expect_cursor("ignored", 1, 0);

        // Direct cursor addressing, including saturation both ways.
        send(8'h1B); send(8'h59); send(8'h25); send(8'h2A);
        expect_cursor("esc_y", 5, 10);
        send(8'h1B); send(8'h59); send(8'h7F); send(8'h7F);
        expect_cursor("esc_y_hi", 15, 63);
        send(8'h1B); send(8'h59); send(8'h10); send(8'h1F);
        expect_cursor("esc_y_lo", 0, 0);

        // ESC K at (2,60): four blanks at 0x0BC..0x0BF.
        send(8'h1B); send(8'h59); send(8'h22); send(8'h5C);
        for (int i = 0; i < 4; i++) push(10'h0BC + 10'(i), 8'h20);
        send(8'h1B); send(8'h4B);
        count_busy(busy);
        check("k_busy", 32'(busy), 32'd4);
        expect_cursor("k_cursor", 2, 60);

        // LF on the bottom row scrolls and blanks logical row 15 (now phys 0).
        send(8'h1B); send(8'h59); send(8'h2F); send(8'h20);
        expect_cursor("bottom", 15, 0);
        for (int i = 0; i < 64; i++) push(10'(i), 8'h20);
        send(8'h0A);
        check("lf_first_row", 32'(first_row), 32'd1);
        count_busy(busy);
        check("lf_busy", 32'(busy), 32'd64);
        expect_cursor("lf_cursor", 15, 0);
        check("lf_q_empty", 32'(exp_q.size()), 32'd0);

        // ESC J from (15,62): two blanks at phys row 0 (15+1 wraps).
        send(8'h1B); send(8'h59); send(8'h2F); send(8'h5E);
        push(10'h03E, 8'h20);
        push(10'h03F, 8'h20);
        send(8'h1B); send(8'h4A);
        count_busy(busy);
        check("j_busy", 32'(busy), 32'd2);
        expect_cursor("j_cursor", 15, 62);

        // Printable after scroll lands on the rotated row.
        push(10'h03E, 8'h51);
        send(8'h51);
        expect_cursor("q_after_scroll", 15, 63);

        // Full-screen clear from home, aborted by reset.
        send(8'h1B); send(8'h48);
        for (int i = 0; i < 1024; i++)
            push({4'((i >> 6) + 1), 6'(i % 64)}, 8'h20);
        send(8'h1B); send(8'h4A);
        check("big_clear_busy", 32'(ready), 32'd0);
        repeat (5) @(posedge pclk);
        #1;
        clr = 1'b1;
        exp_q.delete();
        #1;
        check("abort_wen", 32'(buffer_wen), 32'd0);
        @(posedge pclk);
        #1;
        clr = 1'b0;
        @(posedge pclk);
        #1;
        check("abort_ready",     32'(ready),       32'd1);
        check("abort_first_row", 32'(first_row),   32'd0);
        check("abort_addr",      32'(buffer_addr), 32'd0);
        check("abort_din",       32'(buffer_din),  32'd0);
        expect_cursor("abort", 0, 0);
        repeat (10) @(posedge pclk);
        #1;
        check("abort_wen_idle", 32'(buffer_wen), 32'd0);

        // Back to normal operation after the abort.
        push(10'h000, 8'h7E);
        send(8'h7E);
        expect_cursor("post_abort", 0, 1);

        repeat (5) @(posedge pclk);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
